// File: rtl/memmap_pkg.sv
// Shared types and default memory map for the CPU-to-memory bus controller.
// Latency: n/a (constants, types and a sizing helper only).
// Backpressure: n/a.
package memmap_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Default board memory map (20-bit address space)
    localparam logic [19:0] RAM_BASE  = 20'h00000;
    localparam logic [19:0] RAM_LAST  = 20'h07FFF;
    localparam logic [19:0] TEXT_BASE = 20'hB8000;
    localparam logic [19:0] TEXT_LAST = 20'hB8FFF;
    localparam logic [19:0] BIOS_BASE = 20'hF0000;
    localparam logic [19:0] BIOS_LAST = 20'hFFFFF;
    localparam logic [19:0] EXT_BASE  = 20'h08000;
    localparam logic [19:0] EXT_LAST  = 20'h0FFFF;

    // Region i sits at bits [i*20 +: 20]; index 0 is the lowest slice
    localparam logic [79:0] DEF_REG_BASE = {EXT_BASE, BIOS_BASE, TEXT_BASE, RAM_BASE};
    localparam logic [79:0] DEF_REG_LAST = {EXT_LAST, BIOS_LAST, TEXT_LAST, RAM_LAST};
    localparam logic [11:0] DEF_REG_WAIT = {3'd3, 3'd1, 3'd0, 3'd0};

    // Value returned for reads that hit no region; sliced to DATA_W by users
    localparam logic [63:0] UNMAPPED_DATA = '1;

    // Width of a region index; never zero so a single-region build still compiles
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/memmap_decode.sv
// Priority address decoder: maps an address to region hit, index and base.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated continuously from the address input.
module memmap_decode
    import memmap_pkg::*;
#(
    parameter int                     ADDR_W   = 20,
    parameter int                     NREG     = 4,
    parameter int                     IDX_W    = idx_width(NREG),
    parameter logic [NREG*ADDR_W-1:0] REG_BASE = DEF_REG_BASE,
    parameter logic [NREG*ADDR_W-1:0] REG_LAST = DEF_REG_LAST
)(
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_hit,
    output logic [IDX_W-1:0]  o_idx,
    output logic [ADDR_W-1:0] o_base
);

    // Scan from the highest index down so the lowest matching region wins on overlap
    always_comb begin
        o_hit  = 1'b0;
        o_idx  = '0;
        o_base = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if ((i_addr >= REG_BASE[i*ADDR_W +: ADDR_W]) &&
                (i_addr <= REG_LAST[i*ADDR_W +: ADDR_W])) begin
                o_hit  = 1'b1;
                o_idx  = IDX_W'(i);
                o_base = REG_BASE[i*ADDR_W +: ADDR_W];
            end
        end
    end

endmodule

// File: rtl/memmap_bus.sv
// CPU-to-memory bus controller: region decode, per-region wait states, one-cycle write strobe.
// Latency: mapped access completes 2+W cycles after the request edge, unmapped after 1.
// Backpressure: cpu_req held until the cpu_ready pulse; new requests only taken in IDLE.
// Optional MEMMAP_FAULT_EN adds sticky fault / fault_addr capture of the first unmapped access.
module memmap_bus
    import memmap_pkg::*;
#(
    parameter int                     ADDR_W   = 20,
    parameter int                     DATA_W   = 8,
    parameter int                     NREG     = 4,
    parameter int                     WAIT_W   = 3,
    parameter logic [NREG*ADDR_W-1:0] REG_BASE = DEF_REG_BASE,
    parameter logic [NREG*ADDR_W-1:0] REG_LAST = DEF_REG_LAST,
    parameter logic [NREG*WAIT_W-1:0] REG_WAIT = DEF_REG_WAIT
)(
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        cpu_address,
    input  logic [DATA_W-1:0]        cpu_out,
    input  logic                     cpu_we,
    input  logic                     cpu_req,
    output logic [DATA_W-1:0]        cpu_in,
    output logic                     cpu_ready,
`ifdef MEMMAP_FAULT_EN
    output logic                     fault,
    output logic [ADDR_W-1:0]        fault_addr,
`endif
    output logic [ADDR_W-1:0]        mem_a,
    output logic [DATA_W-1:0]        mem_d,
    output logic [NREG-1:0]          mem_w,
    input  logic [NREG*DATA_W-1:0]   mem_q
);

    localparam int IDX_W = idx_width(NREG);

    state_t              r_state;
    state_t              w_next;
    logic [WAIT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic                r_we;
    logic [ADDR_W-1:0]   r_mem_a;
    logic [DATA_W-1:0]   r_mem_d;
    logic [NREG-1:0]     r_mem_w;
    logic [DATA_W-1:0]   r_cpu_in;

    logic                w_hit;
    logic [IDX_W-1:0]    w_idx;
    logic [ADDR_W-1:0]   w_base;
    logic [WAIT_W-1:0]   w_wait;
    logic [DATA_W-1:0]   w_q_sel;
    logic                w_accept;
    logic                w_last_access;

    memmap_decode #(
        .ADDR_W   (ADDR_W),
        .NREG     (NREG),
        .IDX_W    (IDX_W),
        .REG_BASE (REG_BASE),
        .REG_LAST (REG_LAST)
    ) u_decode (
        .i_addr (cpu_address),
        .o_hit  (w_hit),
        .o_idx  (w_idx),
        .o_base (w_base)
    );

    assign w_wait  = REG_WAIT[w_idx*WAIT_W +: WAIT_W];
    assign w_q_sel = mem_q[r_idx*DATA_W +: DATA_W];

    // State register
    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic: wait counter reaching zero ends the access phase
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (cpu_req) w_next = w_hit ? ST_ACCESS : ST_DONE;
            ST_ACCESS: if (r_cnt == '0) w_next = ST_DONE;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs and strobes for the datapath
    always_comb begin
        cpu_ready     = (r_state == ST_DONE);
        w_accept      = (r_state == ST_IDLE) && cpu_req;
        w_last_access = (r_state == ST_ACCESS) && (r_cnt == '0);
    end

    // Datapath: latch the request, count wait states, capture read data
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_we     <= 1'b0;
            r_mem_a  <= '0;
            r_mem_d  <= '0;
            r_mem_w  <= '0;
            r_cpu_in <= UNMAPPED_DATA[DATA_W-1:0];
        end else begin
            // Write strobe lives for the first ACCESS cycle only
            r_mem_w <= '0;
            if (w_accept) begin
                r_mem_a <= cpu_address - w_base;
                r_mem_d <= cpu_out;
                r_we    <= cpu_we;
                r_idx   <= w_idx;
                r_cnt   <= w_wait;
                if (w_hit && cpu_we)
                    r_mem_w <= NREG'(1) << w_idx;
                if (!w_hit && !cpu_we)
                    r_cpu_in <= UNMAPPED_DATA[DATA_W-1:0];
            end else if (r_state == ST_ACCESS) begin
                if (r_cnt != '0)
                    r_cnt <= r_cnt - WAIT_W'(1);
                if (w_last_access && !r_we)
                    r_cpu_in <= w_q_sel;
            end
        end
    end

`ifdef MEMMAP_FAULT_EN
    logic              r_fault;
    logic [ADDR_W-1:0] r_fault_addr;

    // Sticky record of the first unmapped access since reset
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fault      <= 1'b0;
            r_fault_addr <= '0;
        end else if (w_accept && !w_hit && !r_fault) begin
            r_fault      <= 1'b1;
            r_fault_addr <= cpu_address;
        end
    end

    assign fault      = r_fault;
    assign fault_addr = r_fault_addr;
`endif

    assign cpu_in = r_cpu_in;
    assign mem_a  = r_mem_a;
    assign mem_d  = r_mem_d;
    assign mem_w  = r_mem_w;

endmodule

// File: tb/tb_memmap_bus.sv
// Self-checking bench for memmap_bus: directed plan cases plus randomized accesses
// compared against a region-table reference model; second instance covers overlapping regions.
// Works with or without MEMMAP_FAULT_EN defined.
module tb_memmap_bus;

    logic        clock = 1'b0;
    logic        reset;
    logic [19:0] cpu_address;
    logic [7:0]  cpu_out;
    logic        cpu_we;
    logic        cpu_req;
    logic [7:0]  cpu_in;
    logic        cpu_ready;
    logic [19:0] mem_a;
    logic [7:0]  mem_d;
    logic [3:0]  mem_w;
    logic [31:0] mem_q;
    logic [7:0]  q_val [4];

    logic [19:0] ov_address;
    logic [7:0]  ov_out;
    logic        ov_we;
    logic        ov_req;
    logic [7:0]  ov_cpu_in;
    logic        ov_ready;
    logic [19:0] ov_mem_a;
    logic [7:0]  ov_mem_d;
    logic [3:0]  ov_mem_w;
    logic [31:0] ov_q;

`ifdef MEMMAP_FAULT_EN
    logic        fault;
    logic [19:0] fault_addr;
    logic        ov_fault;
    logic [19:0] ov_fault_addr;
    logic        exp_fault;
    logic [19:0] exp_fault_addr;
`endif

    int checks = 0;
    int errors = 0;

    // Reference memory map, written straight from the region table
    logic [19:0] base  [4] = '{20'h00000, 20'hB8000, 20'hF0000, 20'h08000};
    logic [19:0] last  [4] = '{20'h07FFF, 20'hB8FFF, 20'hFFFFF, 20'h0FFFF};
    int          waitc [4] = '{0, 0, 1, 3};
    logic [7:0]  exp_cpu_in;

    always #5 clock = ~clock;

    assign mem_q = {q_val[3], q_val[2], q_val[1], q_val[0]};

    memmap_bus dut (
        .clock       (clock),
        .reset       (reset),
        .cpu_address (cpu_address),
        .cpu_out     (cpu_out),
        .cpu_we      (cpu_we),
        .cpu_req     (cpu_req),
        .cpu_in      (cpu_in),
        .cpu_ready   (cpu_ready),
`ifdef MEMMAP_FAULT_EN
        .fault       (fault),
        .fault_addr  (fault_addr),
`endif
        .mem_a       (mem_a),
        .mem_d       (mem_d),
        .mem_w       (mem_w),
        .mem_q       (mem_q)
    );

    memmap_bus #(
        .REG_BASE ({20'h08000, 20'hF0000, 20'hB8000, 20'h00000}),
        .REG_LAST ({20'h0FFFF, 20'hFFFFF, 20'hB8FFF, 20'hFFFFF})
    ) dut_ov (
        .clock       (clock),
        .reset       (reset),
        .cpu_address (ov_address),
        .cpu_out     (ov_out),
        .cpu_we      (ov_we),
        .cpu_req     (ov_req),
        .cpu_in      (ov_cpu_in),
        .cpu_ready   (ov_ready),
`ifdef MEMMAP_FAULT_EN
        .fault       (ov_fault),
        .fault_addr  (ov_fault_addr),
`endif
        .mem_a       (ov_mem_a),
        .mem_d       (ov_mem_d),
        .mem_w       (ov_mem_w),
        .mem_q       (ov_q)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Lowest-numbered region containing the address, or -1
    function automatic int model_region(input logic [19:0] a);
        for (int i = 0; i < 4; i++)
            if (a >= base[i] && a <= last[i]) return i;
        return -1;
    endfunction

    // One CPU access, starting in an IDLE cycle; ends at the negedge of the ready cycle
    task automatic run_access(input logic [19:0] addr, input logic [7:0] data, input logic we,
                              input logic use_qv, input logic [7:0] qv, input logic keep_req);
        int          r;
        int          lat;
        logic [19:0] off;
        logic [3:0]  exp_w;
        @(negedge clock);
        check("idle_no_ready", 32'(cpu_ready), 32'd0);
        for (int i = 0; i < 4; i++) q_val[i] = 8'($urandom);
        r = model_region(addr);
        if (use_qv && r >= 0) q_val[r] = qv;
        lat = (r >= 0) ? waitc[r] + 2 : 1;
        off = (r >= 0) ? addr - base[r] : 20'h0;
        cpu_address = addr;
        cpu_out     = data;
        cpu_we      = we;
        cpu_req     = 1'b1;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clock);
            exp_w = (r >= 0 && we && k == 1) ? 4'(1 << r) : 4'h0;
            check("mem_w", 32'(mem_w), 32'(exp_w));
            check("ready_timing", 32'(cpu_ready), 32'(k == lat));
            if (k < lat) begin
                check("mem_a", 32'(mem_a), 32'(off));
                check("mem_d", 32'(mem_d), 32'(data));
                // Inputs wander during the access; only latched values may matter
                cpu_address = 20'($urandom);
                cpu_out     = 8'($urandom);
                cpu_we      = 1'($urandom);
            end else begin
                if (!we) exp_cpu_in = (r >= 0) ? q_val[r] : 8'hFF;
                check("cpu_in", 32'(cpu_in), 32'(exp_cpu_in));
`ifdef MEMMAP_FAULT_EN
                if (r < 0 && !exp_fault) begin
                    exp_fault      = 1'b1;
                    exp_fault_addr = addr;
                end
                check("fault", 32'(fault), 32'(exp_fault));
                check("fault_addr", 32'(fault_addr), 32'(exp_fault_addr));
`endif
                cpu_req = keep_req;
            end
        end
    endtask

    initial begin
        int          pulses;
        int          ri;
        int          sel;
        logic [19:0] a;
        reset       = 1'b1;
        cpu_address = '0;
        cpu_out     = '0;
        cpu_we      = 1'b0;
        cpu_req     = 1'b0;
        ov_address  = '0;
        ov_out      = '0;
        ov_we       = 1'b0;
        ov_req      = 1'b0;
        ov_q        = '0;
        for (int i = 0; i < 4; i++) q_val[i] = 8'h00;
        exp_cpu_in  = 8'hFF;
`ifdef MEMMAP_FAULT_EN
        exp_fault      = 1'b0;
        exp_fault_addr = '0;
`endif
        repeat (3) @(negedge clock);

        // Reset values
        check("rst_ready", 32'(cpu_ready), 32'd0);
        check("rst_cpu_in", 32'(cpu_in), 32'hFF);
        check("rst_mem_w", 32'(mem_w), 32'd0);
        check("rst_mem_a", 32'(mem_a), 32'd0);
        check("rst_mem_d", 32'(mem_d), 32'd0);
`ifdef MEMMAP_FAULT_EN
        check("rst_fault", 32'(fault), 32'd0);
`endif
        reset = 1'b0;

        // Directed plan cases
        run_access(20'h00010, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b1);
        run_access(20'hB8002, 8'h41, 1'b1, 1'b0, 8'h00, 1'b1);
        run_access(20'h0A000, 8'h00, 1'b0, 1'b1, 8'hC3, 1'b0);
        run_access(20'h50000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        run_access(20'h60000, 8'h77, 1'b1, 1'b0, 8'h00, 1'b0);
        run_access(20'hB8FFF, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        run_access(20'hB9000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

        // Reset in the second ACCESS cycle of a region-2 write
        @(negedge clock);
        cpu_address = 20'hFFFF0;
        cpu_out     = 8'h99;
        cpu_we      = 1'b1;
        cpu_req     = 1'b1;
        pulses      = 0;
        @(negedge clock);
        if (mem_w[2]) pulses++;
        check("abort_first_w", 32'(mem_w), 32'h4);
        check("abort_ready1", 32'(cpu_ready), 32'd0);
        @(negedge clock);
        if (mem_w[2]) pulses++;
        check("abort_ready2", 32'(cpu_ready), 32'd0);
        reset   = 1'b1;
        cpu_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            if (mem_w[2]) pulses++;
            check("abort_ready_after", 32'(cpu_ready), 32'd0);
            check("abort_mem_w_after", 32'(mem_w), 32'd0);
            check("abort_mem_a", 32'(mem_a), 32'd0);
            reset = 1'b0;
        end
        check("abort_cpu_in", 32'(cpu_in), 32'hFF);
        check("abort_pulses", 32'(pulses), 32'd1);
        exp_cpu_in = 8'hFF;
`ifdef MEMMAP_FAULT_EN
        exp_fault      = 1'b0;
        exp_fault_addr = '0;
        check("abort_fault", 32'(fault), 32'd0);
`endif

        // Randomized accesses, biased toward region edges
        for (int n = 0; n < 300; n++) begin
            ri  = $urandom_range(0, 3);
            sel = $urandom_range(0, 5);
            case (sel)
                0:       a = base[ri];
                1:       a = last[ri];
                2:       a = base[ri] - 20'd1;
                3:       a = last[ri] + 20'd1;
                4:       a = 20'($urandom_range(32'(base[ri]), 32'(last[ri])));
                default: a = 20'($urandom);
            endcase
            run_access(a, 8'($urandom), 1'($urandom), 1'b0, 8'h00, 1'($urandom));
            if (!cpu_req) repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        @(negedge clock);
        cpu_req = 1'b0;

        // Overlapping map: region 0 spans everything, so 0xB8000 lands in region 0
        @(negedge clock);
        ov_q       = 32'hC3B2A15A;
        ov_address = 20'hB8000;
        ov_out     = 8'h3C;
        ov_we      = 1'b0;
        ov_req     = 1'b1;
        @(negedge clock);
        check("ov_mem_a", 32'(ov_mem_a), 32'hB8000);
        check("ov_mem_d", 32'(ov_mem_d), 32'h3C);
        check("ov_mem_w", 32'(ov_mem_w), 32'd0);
        check("ov_ready_early", 32'(ov_ready), 32'd0);
        @(negedge clock);
        check("ov_ready", 32'(ov_ready), 32'd1);
        check("ov_cpu_in", 32'(ov_cpu_in), 32'h5A);
`ifdef MEMMAP_FAULT_EN
        check("ov_fault", 32'(ov_fault), 32'd0);
        check("ov_fault_addr", 32'(ov_fault_addr), 32'd0);
`endif
        ov_req = 1'b0;
        @(negedge clock);
        check("ov_ready_gone", 32'(ov_ready), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
